// File: rtl/polar_pkg.sv
// Shared constants and state encoding for the SC polar decoder datapath.
// The partial-sum updater and the top-level decoder FSM both import this package.
package polar_pkg;

    localparam int CODE_LEN         = 1024;
    localparam int LOG2N            = 10;
    localparam int ID_COUNTER_WIDTH = 10;
    localparam int ADDR_WIDTH       = 10;
    localparam int LAYER_WIDTH      = $clog2(LOG2N + 1);

    typedef enum logic [2:0] {
        PS_IDLE,
        PS_SETUP,
        PS_RD_ISSUE,
        PS_RD_ACC,
        PS_WRITE,
        PS_DONE
    } ps_state_e;

    // Trailing ones of a bit index give the size (2^t) of the subtree it completes.
    function automatic logic [LAYER_WIDTH-1:0] trailing_ones(input logic [ID_COUNTER_WIDTH-1:0] idx);
        logic [LAYER_WIDTH-1:0] cnt;
        logic                   run;
        cnt = '0;
        run = 1'b1;
        for (int b = 0; b < ID_COUNTER_WIDTH; b++) begin
            if (run && idx[b]) begin
                cnt = cnt + LAYER_WIDTH'(1);
            end else begin
                run = 1'b0;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lowest_zero_bit_find.sv
// Finds the lowest layer s in [start, limit) where k has a zero bit.
// Those are exactly the left-subtree regions that contribute to V[k].
module lowest_zero_bit_find
    import polar_pkg::*;
(
    input  logic [ADDR_WIDTH-1:0]  i_k,
    input  logic [LAYER_WIDTH-1:0] i_start,
    input  logic [LAYER_WIDTH-1:0] i_limit,
    output logic [LAYER_WIDTH-1:0] o_pos,
    output logic                   o_found
);

    // Scan from the top down so the lowest qualifying position wins.
    always_comb begin
        o_pos   = '0;
        o_found = 1'b0;
        for (int p = LOG2N - 1; p >= 0; p--) begin
            if ((LAYER_WIDTH'(p) >= i_start) && (LAYER_WIDTH'(p) < i_limit) && !i_k[p]) begin
                o_pos   = LAYER_WIDTH'(p);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/partial_sum_updater.sv
// Updates the heap-organised partial-sum BRAM after each decided bit u_i,
// writing region t = trailing_ones(i) from u_i and the lower left-subtree regions.
module partial_sum_updater
    import polar_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        bit_valid,
    input  logic                        bit_value,
    input  logic [ID_COUNTER_WIDTH-1:0] bit_index,
    output logic                        ps_busy,
    output logic                        ps_update_fin,
    output logic [ADDR_WIDTH-1:0]       ps_addr,
    output logic                        ps_en,
    output logic                        ps_we,
    output logic                        ps_wdata,
    input  logic                        ps_rdata
);

    ps_state_e              r_state;
    logic                   r_u;
    logic                   r_acc;
    logic [LAYER_WIDTH-1:0] r_t;
    logic [LAYER_WIDTH-1:0] r_s;
    logic [ADDR_WIDTH-1:0]  r_k;

    ps_state_e              w_stateNext;
    logic                   w_uNext;
    logic                   w_accNext;
    logic [LAYER_WIDTH-1:0] w_tNext;
    logic [LAYER_WIDTH-1:0] w_sNext;
    logic [ADDR_WIDTH-1:0]  w_kNext;

    logic [ADDR_WIDTH-1:0]  w_findK;
    logic [LAYER_WIDTH-1:0] w_findStart;
    logic [LAYER_WIDTH-1:0] w_findPos;
    logic                   w_found;

    logic [ADDR_WIDTH-1:0]  w_sBase;
    logic [ADDR_WIDTH-1:0]  w_tBase;
    logic [ADDR_WIDTH-1:0]  w_readAddr;
    logic [ADDR_WIDTH-1:0]  w_writeAddr;
    logic                   w_lastK;

    assign w_sBase     = ADDR_WIDTH'(1) << r_s;
    assign w_tBase     = ADDR_WIDTH'(1) << r_t;
    assign w_readAddr  = w_sBase + (r_k & (w_sBase - ADDR_WIDTH'(1)));
    assign w_writeAddr = w_tBase + r_k;
    assign w_lastK     = (r_k == (w_tBase - ADDR_WIDTH'(1)));

    // After a write the search runs on k+1; after an accumulate it resumes above s.
    always_comb begin
        w_findK     = r_k;
        w_findStart = '0;
        case (r_state)
            PS_RD_ACC: w_findStart = r_s + LAYER_WIDTH'(1);
            PS_WRITE:  w_findK     = r_k + ADDR_WIDTH'(1);
            default:   ;
        endcase
    end

    lowest_zero_bit_find u_find (
        .i_k     (w_findK),
        .i_start (w_findStart),
        .i_limit (r_t),
        .o_pos   (w_findPos),
        .o_found (w_found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= PS_IDLE;
            r_u     <= 1'b0;
            r_acc   <= 1'b0;
            r_t     <= '0;
            r_s     <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_stateNext;
            r_u     <= w_uNext;
            r_acc   <= w_accNext;
            r_t     <= w_tNext;
            r_s     <= w_sNext;
            r_k     <= w_kNext;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_uNext       = r_u;
        w_accNext     = r_acc;
        w_tNext       = r_t;
        w_sNext       = r_s;
        w_kNext       = r_k;
        ps_busy       = (r_state != PS_IDLE);
        ps_update_fin = 1'b0;
        ps_addr       = '0;
        ps_en         = 1'b0;
        ps_we         = 1'b0;
        ps_wdata      = 1'b0;

        case (r_state)
            PS_IDLE: begin
                if (bit_valid) begin
                    w_uNext     = bit_value;
                    w_tNext     = trailing_ones(bit_index);
                    w_kNext     = '0;
                    w_accNext   = 1'b0;
                    w_stateNext = PS_SETUP;
                end
            end
            PS_SETUP: begin
                w_accNext = r_u;
                if (r_t == LAYER_WIDTH'(LOG2N)) begin
                    w_stateNext = PS_DONE;
                end else if (w_found) begin
                    w_sNext     = w_findPos;
                    w_stateNext = PS_RD_ISSUE;
                end else begin
                    w_stateNext = PS_WRITE;
                end
            end
            PS_RD_ISSUE: begin
                ps_en       = 1'b1;
                ps_addr     = w_readAddr;
                w_stateNext = PS_RD_ACC;
            end
            PS_RD_ACC: begin
                w_accNext = r_acc ^ ps_rdata;
                if (w_found) begin
                    w_sNext     = w_findPos;
                    w_stateNext = PS_RD_ISSUE;
                end else begin
                    w_stateNext = PS_WRITE;
                end
            end
            PS_WRITE: begin
                ps_en    = 1'b1;
                ps_we    = 1'b1;
                ps_addr  = w_writeAddr;
                ps_wdata = r_acc;
                if (w_lastK) begin
                    w_stateNext = PS_DONE;
                end else begin
                    w_kNext   = r_k + ADDR_WIDTH'(1);
                    w_accNext = r_u;
                    if (w_found) begin
                        w_sNext     = w_findPos;
                        w_stateNext = PS_RD_ISSUE;
                    end else begin
                        w_stateNext = PS_WRITE;
                    end
                end
            end
            PS_DONE: begin
                ps_update_fin = 1'b1;
                w_stateNext   = PS_IDLE;
            end
            default: w_stateNext = PS_IDLE;
        endcase
    end

endmodule

// File: tb/tb_partial_sum_updater.sv
// Bench for partial_sum_updater: BRAM model, directed vector table, hand sequences,
// and a random full codeword checked against a polar-transform reference.
module tb_partial_sum_updater;

    localparam int N    = 1024;
    localparam int LOGN = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_valid;
    logic       bit_value;
    logic [9:0] bit_index;
    logic       ps_busy;
    logic       ps_update_fin;
    logic [9:0] ps_addr;
    logic       ps_en;
    logic       ps_we;
    logic       ps_wdata;
    logic       ps_rdata;

    int checks   = 0;
    int failures = 0;

    partial_sum_updater dut (
        .clk           (clk),
        .reset         (reset),
        .bit_valid     (bit_valid),
        .bit_value     (bit_value),
        .bit_index     (bit_index),
        .ps_busy       (ps_busy),
        .ps_update_fin (ps_update_fin),
        .ps_addr       (ps_addr),
        .ps_en         (ps_en),
        .ps_we         (ps_we),
        .ps_wdata      (ps_wdata),
        .ps_rdata      (ps_rdata)
    );

    always #5 clk = ~clk;

    logic       psMem [0:N-1];
    logic       reqEn = 1'b0;
    logic       reqWe = 1'b0;
    logic       reqData = 1'b0;
    logic [9:0] reqAddr = '0;
    int         nReads;
    int         nWrites;
    int         rdAddrQ[$];
    int         wrAddrQ[$];
    logic       wrDataQ[$];

    // Requests are captured mid-cycle and serviced at the next rising edge (1-cycle read latency).
    always @(negedge clk) begin
        reqEn   = ps_en;
        reqWe   = ps_we;
        reqAddr = ps_addr;
        reqData = ps_wdata;
        if (ps_en) begin
            if (ps_we) begin
                nWrites++;
                wrAddrQ.push_back(int'(ps_addr));
                wrDataQ.push_back(ps_wdata);
            end else begin
                nReads++;
                rdAddrQ.push_back(int'(ps_addr));
            end
        end
    end

    always @(posedge clk) begin
        if (reqEn) begin
            if (reqWe) psMem[reqAddr] <= reqData;
            else       ps_rdata <= psMem[reqAddr];
        end
    end

    typedef struct {
        int   idx;
        logic u;
        int   expLat;
        int   expReads;
        int   expWrites;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic u, input int injectAt, output int lat);
        nReads  = 0;
        nWrites = 0;
        rdAddrQ.delete();
        wrAddrQ.delete();
        wrDataQ.delete();
        @(negedge clk);
        bit_index = idx[9:0];
        bit_value = u;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        bit_index = 10'd0;
        bit_value = 1'b1;
        lat = 1;
        checkOutput($sformatf("busy_cycle1 i=%0d", idx), 32'(ps_busy), 32'd1);
        while (!ps_update_fin && lat < 6000) begin
            @(negedge clk);
            lat++;
            bit_valid = (lat == injectAt);
        end
        bit_valid = 1'b0;
        checkOutput($sformatf("fin_reached i=%0d", idx), 32'(ps_update_fin), 32'd1);
    endtask

    function automatic int modelTrailingOnes(input int idx);
        int t = 0;
        while (t < LOGN && idx[t]) t++;
        return t;
    endfunction

    // Cycle of ps_update_fin: 1 + sum over k of (2*zeros_t(k) + 1) + 1.
    function automatic int modelLatency(input int t);
        int sum = 0;
        if (t == LOGN) return 2;
        for (int k = 0; k < (1 << t); k++) begin
            int zeros = 0;
            for (int b = 0; b < t; b++) if (((k >> b) & 1) == 0) zeros++;
            sum += 2 * zeros + 1;
        end
        return 2 + sum;
    endfunction

    int   uBits [0:N-1];
    logic xVec  [0:N-1];

    initial begin
        vec_t tbl [5];
        int   lat;
        int   expRd [4];
        int   expWrA[4];
        logic expWrD[4];

        reset     = 1'b0;
        bit_valid = 1'b0;
        bit_value = 1'b0;
        bit_index = '0;
        ps_rdata  = 1'b0;
        for (int a = 0; a < N; a++) psMem[a] = 1'b0;

        tbl[0] = '{idx: 0,    u: 1'b1, expLat: 3,  expReads: 0,  expWrites: 1};
        tbl[1] = '{idx: 2,    u: 1'b0, expLat: 3,  expReads: 0,  expWrites: 1};
        tbl[2] = '{idx: 5,    u: 1'b1, expLat: 6,  expReads: 1,  expWrites: 2};
        tbl[3] = '{idx: 7,    u: 1'b0, expLat: 34, expReads: 12, expWrites: 8};
        tbl[4] = '{idx: 1023, u: 1'b1, expLat: 2,  expReads: 0,  expWrites: 0};

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    32'({ps_busy, ps_update_fin, ps_en, ps_we, ps_wdata, ps_addr}), 32'd0);
        reset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            applyStimulus(tbl[v].idx, tbl[v].u, 0, lat);
            checkOutput($sformatf("tbl%0d_latency", v), 32'(lat), 32'(tbl[v].expLat));
            checkOutput($sformatf("tbl%0d_reads", v), 32'(nReads), 32'(tbl[v].expReads));
            checkOutput($sformatf("tbl%0d_writes", v), 32'(nWrites), 32'(tbl[v].expWrites));
        end

        // i=1, u=0 with L_0 = {1}: one read of addr 1, then region 1 becomes {1, 0}.
        psMem[1] = 1'b1;
        applyStimulus(1, 1'b0, 0, lat);
        checkOutput("seqA_latency", 32'(lat), 32'd6);
        checkOutput("seqA_nreads", 32'(rdAddrQ.size()), 32'd1);
        checkOutput("seqA_read0", 32'((rdAddrQ.size() > 0) ? rdAddrQ[0] : -1), 32'd1);
        checkOutput("seqA_mem2", 32'(psMem[2]), 32'd1);
        checkOutput("seqA_mem3", 32'(psMem[3]), 32'd0);

        // i=3, u=1 with L_0={1}, L_1={1,0}: reads 1,2 / 3 / 1; writes 4..7 = 1,1,0,1.
        psMem[1] = 1'b1; psMem[2] = 1'b1; psMem[3] = 1'b0;
        expRd  = '{1, 2, 3, 1};
        expWrA = '{4, 5, 6, 7};
        expWrD = '{1'b1, 1'b1, 1'b0, 1'b1};
        applyStimulus(3, 1'b1, 0, lat);
        checkOutput("seqB_latency", 32'(lat), 32'd14);
        checkOutput("seqB_nreads", 32'(rdAddrQ.size()), 32'd4);
        checkOutput("seqB_nwrites", 32'(wrAddrQ.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("seqB_read%0d", j),
                        32'((j < rdAddrQ.size()) ? rdAddrQ[j] : -1), 32'(expRd[j]));
            checkOutput($sformatf("seqB_waddr%0d", j),
                        32'((j < wrAddrQ.size()) ? wrAddrQ[j] : -1), 32'(expWrA[j]));
            checkOutput($sformatf("seqB_wdata%0d", j),
                        (j < wrDataQ.size()) ? 32'(wrDataQ[j]) : 32'hFFFF_FFFF, 32'(expWrD[j]));
        end

        // Reset in the middle of a long update, with start pulses arriving during reset.
        @(negedge clk);
        bit_index = 10'd7;
        bit_value = 1'b1;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("busy_before_reset", 32'(ps_busy), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_outputs",
                    32'({ps_busy, ps_update_fin, ps_en, ps_we, ps_wdata, ps_addr}), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("held_reset_outputs c=%0d", c),
                        32'({ps_busy, ps_update_fin, ps_en, ps_we, ps_wdata, ps_addr}), 32'd0);
            bit_valid = ~bit_valid;
        end
        @(negedge clk);
        bit_valid = 1'b0;
        reset     = 1'b1;
        applyStimulus(0, 1'b1, 0, lat);
        checkOutput("post_reset_latency", 32'(lat), 32'd3);
        checkOutput("post_reset_writes", 32'(nWrites), 32'd1);
        checkOutput("post_reset_mem1", 32'(psMem[1]), 32'd1);

        // Random codeword; region t after bit i must equal the polar transform of u[i-2^t+1 .. i].
        for (int i = 0; i < N; i++) begin
            int t;
            int n;
            int errs;
            int firstBad;
            uBits[i] = int'($urandom_range(0, 1));
            t = modelTrailingOnes(i);
            applyStimulus(i, uBits[i][0], (i == 63) ? 10 : 0, lat);
            checkOutput($sformatf("cw_latency i=%0d", i), 32'(lat), 32'(modelLatency(t)));
            if (t < LOGN) begin
                n = 1 << t;
                for (int j = 0; j < n; j++) xVec[j] = uBits[i - n + 1 + j][0];
                for (int h = 1; h < n; h = h * 2)
                    for (int j = 0; j < n; j++)
                        if ((j & h) == 0) xVec[j] = xVec[j] ^ xVec[j + h];
                errs = 0;
                firstBad = -1;
                for (int j = 0; j < n; j++) begin
                    if (psMem[n + j] !== xVec[j]) begin
                        errs++;
                        if (firstBad < 0) firstBad = j;
                    end
                end
                checkOutput($sformatf("cw_region i=%0d t=%0d first_bad=%0d", i, t, firstBad),
                            32'(errs), 32'd0);
            end else begin
                checkOutput("cw_last_no_access", 32'(nReads + nWrites), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
